ktms_afu_hangmon: RTL and testbench

Per-channel hang detector sitting directly upstream of the AFU error monitor. Registers up to `channels` valid/ready handshake pairs from the AFU pipeline and times consecutive stall cycles (valid high, ready low) on each pair. It raises a sticky per-channel hang error when a stall reaches a programmable timeout and keeps a saturating event count. Its outputs feed the error monitor's error vector, count and pipe-monitor inputs.

---
 rtl/ktms_hangmon_pkg.sv | 20 ++
 rtl/ktms_afu_hangmon_chan.sv | 53 +++++
 rtl/ktms_afu_hangmon.sv | 125 ++++++++++++
 tb/tb_ktms_afu_hangmon.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ktms_hangmon_pkg.sv
// Shared widths and the saturating accumulator helper for the AFU hang monitor.
package ktms_hangmon_pkg;

    localparam int ERR_CNT_WIDTH  = 32;
    localparam int FIRST_CH_WIDTH = 5;

    // Adds in one extra bit of headroom and clamps to all-ones on carry-out.
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_add_cnt(
        input logic [ERR_CNT_WIDTH-1:0] acc,
        input logic [ERR_CNT_WIDTH-1:0] inc
    );
        logic [ERR_CNT_WIDTH:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum[ERR_CNT_WIDTH]) begin
            return '1;
        end
        return sum[ERR_CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/ktms_afu_hangmon_chan.sv
// Single-channel hang detector: consecutive-stall counter, one-shot timeout
// event per stall episode, and the sticky error bit.
module ktms_hangmon_chan
    import ktms_hangmon_pkg::*;
#(
    parameter int cnt_width = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_s1_stall,
    input  logic [cnt_width-1:0] i_timeout,
    input  logic                 i_clr,
    output logic                 o_ev,
    output logic                 o_err
);

    logic [cnt_width-1:0] r_scnt;
    logic                 r_err;
    logic [cnt_width:0]   w_scnt_inc;

    // Extra MSB keeps the compare free of wrap when the counter is saturated.
    assign w_scnt_inc = {1'b0, r_scnt} + {{cnt_width{1'b0}}, 1'b1};

    // Exact-match compare fires once per episode; a timeout lowered below the
    // running count simply never matches until the counter restarts.
    assign o_ev  = i_s1_stall && (i_timeout != '0) && (w_scnt_inc == {1'b0, i_timeout});
    assign o_err = r_err;

    // Stall counter: count while stalled (holding at all-ones), zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scnt <= '0;
        end else if (i_s1_stall) begin
            if (!w_scnt_inc[cnt_width]) begin
                r_scnt <= w_scnt_inc[cnt_width-1:0];
            end
        end else begin
            r_scnt <= '0;
        end
    end

    // Sticky error: a new event beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (o_ev) begin
            r_err <= 1'b1;
        end else if (i_clr) begin
            r_err <= 1'b0;
        end
    end

endmodule

// File: rtl/ktms_afu_hangmon.sv
// Per-channel AFU handshake hang monitor feeding the error monitor.
// Optional first-error capture is built when KTMS_HANGMON_FIRST_ERR_EN is defined.
module ktms_afu_hangmon
    import ktms_hangmon_pkg::*;
#(
    parameter int channels  = 8,
    parameter int cnt_width = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [channels-1:0]       i_v,
    input  logic [channels-1:0]       i_r,
    input  logic [cnt_width-1:0]      i_timeout,
    input  logic                      i_clr,
    output logic [channels-1:0]       o_err,
    output logic [ERR_CNT_WIDTH-1:0]  o_err_cnt,
    output logic [channels-1:0]       o_pipemon_v,
    output logic [channels-1:0]       o_pipemon_r,
    output logic                      o_first_v,
    output logic [FIRST_CH_WIDTH-1:0] o_first_ch
);

    // Popcount of up to 32 channels needs 6 bits.
    localparam int POP_W = 6;

    logic [channels-1:0]      r_s1_v;
    logic [channels-1:0]      r_s1_r;
    logic [channels-1:0]      w_s1_stall;
    logic [channels-1:0]      w_ev;
    logic [channels-1:0]      w_err;
    logic [POP_W-1:0]         w_ev_pop;
    logic [ERR_CNT_WIDTH-1:0] w_ev_pop_ext;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    // Stage 1: register the raw handshakes; these also feed the pipe monitor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v <= '0;
            r_s1_r <= '0;
        end else begin
            r_s1_v <= i_v;
            r_s1_r <= i_r;
        end
    end

    assign w_s1_stall  = r_s1_v & ~r_s1_r;
    assign o_pipemon_v = r_s1_v;
    assign o_pipemon_r = r_s1_r;

    for (genvar c = 0; c < channels; c++) begin : g_chan
        ktms_hangmon_chan #(
            .cnt_width (cnt_width)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_s1_stall (w_s1_stall[c]),
            .i_timeout  (i_timeout),
            .i_clr      (i_clr),
            .o_ev       (w_ev[c]),
            .o_err      (w_err[c])
        );
    end

    assign o_err = w_err;

    // Number of channels that hit their timeout this cycle.
    always_comb begin
        w_ev_pop = '0;
        for (int c = 0; c < channels; c++) begin
            w_ev_pop = w_ev_pop + {{(POP_W-1){1'b0}}, w_ev[c]};
        end
    end

    assign w_ev_pop_ext = {{(ERR_CNT_WIDTH-POP_W){1'b0}}, w_ev_pop};

    // Event accumulator: a clear restarts from this cycle's events, else saturating add.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (i_clr) begin
            r_err_cnt <= w_ev_pop_ext;
        end else begin
            r_err_cnt <= sat_add_cnt(r_err_cnt, w_ev_pop_ext);
        end
    end

    assign o_err_cnt = r_err_cnt;

`ifdef KTMS_HANGMON_FIRST_ERR_EN
    logic                      r_first_v;
    logic [FIRST_CH_WIDTH-1:0] r_first_ch;
    logic [FIRST_CH_WIDTH-1:0] w_first_idx;

    // Lowest-indexed channel with an event this cycle.
    always_comb begin
        w_first_idx = '0;
        for (int c = channels - 1; c >= 0; c--) begin
            if (w_ev[c]) begin
                w_first_idx = FIRST_CH_WIDTH'(c);
            end
        end
    end

    // First-error capture: a clear re-arms it, using any events of the clear cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_v  <= 1'b0;
            r_first_ch <= '0;
        end else if (i_clr) begin
            r_first_v  <= |w_ev;
            r_first_ch <= (|w_ev) ? w_first_idx : '0;
        end else if (!r_first_v && (|w_ev)) begin
            r_first_v  <= 1'b1;
            r_first_ch <= w_first_idx;
        end
    end

    assign o_first_v  = r_first_v;
    assign o_first_ch = r_first_ch;
`else
    assign o_first_v  = 1'b0;
    assign o_first_ch = '0;
`endif

endmodule

// File: tb/tb_ktms_afu_hangmon.sv
// Directed bench for ktms_afu_hangmon (8 channels, 8-bit stall counter).
module tb_ktms_afu_hangmon;
    import ktms_hangmon_pkg::*;

    localparam int CH = 8;
    localparam int CW = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [CH-1:0]             i_v;
    logic [CH-1:0]             i_r;
    logic [CW-1:0]             i_timeout;
    logic                      i_clr;
    logic [CH-1:0]             o_err;
    logic [ERR_CNT_WIDTH-1:0]  o_err_cnt;
    logic [CH-1:0]             o_pipemon_v;
    logic [CH-1:0]             o_pipemon_r;
    logic                      o_first_v;
    logic [FIRST_CH_WIDTH-1:0] o_first_ch;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ktms_afu_hangmon #(
        .channels  (CH),
        .cnt_width (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_v         (i_v),
        .i_r         (i_r),
        .i_timeout   (i_timeout),
        .i_clr       (i_clr),
        .o_err       (o_err),
        .o_err_cnt   (o_err_cnt),
        .o_pipemon_v (o_pipemon_v),
        .o_pipemon_r (o_pipemon_r),
        .o_first_v   (o_first_v),
        .o_first_ch  (o_first_ch)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_clear();
        i_v   = '0;
        i_r   = '0;
        i_clr = 1'b1;
        step(1);
        i_clr = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1; i_v = '0; i_r = '0; i_timeout = '0; i_clr = 1'b0;
        step(2);
        n_checks++; if (o_err !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %h want 00", o_err); end
        n_checks++; if (o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", o_err_cnt); end
        n_checks++; if (o_pipemon_v !== 8'h00 || o_pipemon_r !== 8'h00) begin n_fail++; $display("FAIL reset_pipemon: got v=%h r=%h want 00/00", o_pipemon_v, o_pipemon_r); end
        n_checks++; if (o_first_v !== 1'b0 || o_first_ch !== 5'd0) begin n_fail++; $display("FAIL reset_first: got v=%b ch=%0d want 0/0", o_first_v, o_first_ch); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_pipemon();
        i_v = 8'hA5; i_r = 8'h3C;
        n_checks++; if (o_pipemon_v !== 8'h00) begin n_fail++; $display("FAIL pipemon_lag: got %h want 00", o_pipemon_v); end
        step(1);
        n_checks++; if (o_pipemon_v !== 8'hA5 || o_pipemon_r !== 8'h3C) begin n_fail++; $display("FAIL pipemon_copy: got v=%h r=%h want A5/3C", o_pipemon_v, o_pipemon_r); end
        i_v = 8'h00; i_r = 8'h00;
        step(2);
        n_checks++; if (o_pipemon_v !== 8'h00 || o_err !== 8'h00) begin n_fail++; $display("FAIL pipemon_idle: got v=%h err=%h want 00/00", o_pipemon_v, o_err); end
    endtask

    task automatic test_hang_latency();
        i_timeout = 8'd4; i_v = 8'h04; i_r = 8'h00;
        step(4);
        n_checks++; if (o_err !== 8'h00) begin n_fail++; $display("FAIL t1_early: got %h want 00", o_err); end
        step(1);
        n_checks++; if (o_err !== 8'h04) begin n_fail++; $display("FAIL t1_err: got %h want 04", o_err); end
        n_checks++; if (o_err_cnt !== 32'd1) begin n_fail++; $display("FAIL t1_cnt: got %0d want 1", o_err_cnt); end
`ifdef KTMS_HANGMON_FIRST_ERR_EN
        n_checks++; if (o_first_v !== 1'b1 || o_first_ch !== 5'd2) begin n_fail++; $display("FAIL t1_first: got v=%b ch=%0d want 1/2", o_first_v, o_first_ch); end
`else
        n_checks++; if (o_first_v !== 1'b0 || o_first_ch !== 5'd0) begin n_fail++; $display("FAIL t1_first_off: got v=%b ch=%0d want 0/0", o_first_v, o_first_ch); end
`endif
        step(100);
        n_checks++; if (o_err !== 8'h04 || o_err_cnt !== 32'd1) begin n_fail++; $display("FAIL t1_hold: got err=%h cnt=%0d want 04/1", o_err, o_err_cnt); end
        idle_clear();
        n_checks++; if (o_err !== 8'h00 || o_err_cnt !== 32'd0 || o_first_v !== 1'b0) begin n_fail++; $display("FAIL clr: got err=%h cnt=%0d fv=%b want 00/0/0", o_err, o_err_cnt, o_first_v); end
    endtask

    task automatic test_no_hang();
        i_timeout = 8'd4; i_v = 8'h04; i_r = 8'h00;
        step(3);
        i_r = 8'h04;
        step(1);
        i_r = 8'h00;
        step(3);
        i_v = 8'h00;
        step(3);
        n_checks++; if (o_err !== 8'h00 || o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL t2_no_hang: got err=%h cnt=%0d want 00/0", o_err, o_err_cnt); end
    endtask

    task automatic test_simultaneous();
        i_timeout = 8'd3; i_v = 8'h21; i_r = 8'h00;
        step(3);
        n_checks++; if (o_err !== 8'h00) begin n_fail++; $display("FAIL t3_early: got %h want 00", o_err); end
        step(1);
        n_checks++; if (o_err !== 8'h21) begin n_fail++; $display("FAIL t3_err: got %h want 21", o_err); end
        n_checks++; if (o_err_cnt !== 32'd2) begin n_fail++; $display("FAIL t3_cnt: got %0d want 2", o_err_cnt); end
`ifdef KTMS_HANGMON_FIRST_ERR_EN
        n_checks++; if (o_first_v !== 1'b1 || o_first_ch !== 5'd0) begin n_fail++; $display("FAIL t3_first: got v=%b ch=%0d want 1/0", o_first_v, o_first_ch); end
`endif
        i_v = 8'h00;
        step(2);
    endtask

    task automatic test_clr_vs_event();
        i_timeout = 8'd4; i_v = 8'h02; i_r = 8'h00;
        step(4);
        n_checks++; if (o_err !== 8'h21) begin n_fail++; $display("FAIL t4_pre: got %h want 21", o_err); end
        i_clr = 1'b1;
        step(1);
        i_clr = 1'b0;
        n_checks++; if (o_err !== 8'h02) begin n_fail++; $display("FAIL t4_err: got %h want 02", o_err); end
        n_checks++; if (o_err_cnt !== 32'd1) begin n_fail++; $display("FAIL t4_cnt: got %0d want 1", o_err_cnt); end
`ifdef KTMS_HANGMON_FIRST_ERR_EN
        n_checks++; if (o_first_v !== 1'b1 || o_first_ch !== 5'd1) begin n_fail++; $display("FAIL t4_first: got v=%b ch=%0d want 1/1", o_first_v, o_first_ch); end
`endif
        idle_clear();
    endtask

    task automatic test_timeout_lowered();
        i_timeout = 8'd10; i_v = 8'h01; i_r = 8'h00;
        step(6);
        i_timeout = 8'd3;
        step(20);
        n_checks++; if (o_err !== 8'h00 || o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL lowered_mid: got err=%h cnt=%0d want 00/0", o_err, o_err_cnt); end
        i_v = 8'h00;
        step(2);
        i_v = 8'h01;
        step(4);
        n_checks++; if (o_err !== 8'h01 || o_err_cnt !== 32'd1) begin n_fail++; $display("FAIL lowered_next: got err=%h cnt=%0d want 01/1", o_err, o_err_cnt); end
        idle_clear();
    endtask

    task automatic test_saturation();
        logic [31:0] r;
        r = sat_add_cnt(32'hFFFF_FFFE, 32'd2);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_fe_2: got %h want FFFFFFFF", r); end
        r = sat_add_cnt(32'hFFFF_FFFF, 32'd1);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold: got %h want FFFFFFFF", r); end
        r = sat_add_cnt(32'hFFFF_FFFD, 32'd1);
        n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_below: got %h want FFFFFFFE", r); end
        r = sat_add_cnt(32'd5, 32'd3);
        n_checks++; if (r !== 32'd8) begin n_fail++; $display("FAIL sat_plain: got %h want 8", r); end
    endtask

    task automatic test_no_wrap();
        i_timeout = 8'd0; i_v = 8'hFF; i_r = 8'h00;
        step((1 << CW) + 10);
        n_checks++; if (o_err !== 8'h00 || o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL t6_disabled: got err=%h cnt=%0d want 00/0", o_err, o_err_cnt); end
        i_timeout = 8'hFF;
        step(300);
        n_checks++; if (o_err !== 8'h00 || o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL t6_no_wrap: got err=%h cnt=%0d want 00/0", o_err, o_err_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        i_v = 8'h00;
        step(2);
        i_timeout = 8'd4; i_v = 8'hFF;
        step(4);
        reset = 1'b1;
        #1;
        n_checks++; if (o_err !== 8'h00 || o_err_cnt !== 32'd0 || o_pipemon_v !== 8'h00) begin n_fail++; $display("FAIL rst_async: got err=%h cnt=%0d pv=%h want 00/0/00", o_err, o_err_cnt, o_pipemon_v); end
        step(1);
        reset = 1'b0;
        step(4);
        n_checks++; if (o_err !== 8'h00) begin n_fail++; $display("FAIL rst_early: got %h want 00", o_err); end
        step(1);
        n_checks++; if (o_err !== 8'hFF || o_err_cnt !== 32'd8) begin n_fail++; $display("FAIL rst_restart: got err=%h cnt=%0d want FF/8", o_err, o_err_cnt); end
    endtask

    initial begin
        test_reset();
        test_pipemon();
        test_hang_latency();
        test_no_hang();
        test_simultaneous();
        test_clr_vs_event();
        test_timeout_lowered();
        test_saturation();
        test_no_wrap();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
